// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master bridge.
package apb_master_pkg;

  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  // Bridge state; the psel/penable pattern is visible in the two bits.
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'b00;
  localparam state_t SETUP  = 2'b10;
  localparam state_t ACCESS = 2'b11;
  localparam state_t RESP   = 2'b01;

  // Completion status reported with each response.
  typedef logic status_t;
  localparam status_t OK      = 1'b0;
  localparam status_t TIMEOUT = 1'b1;

  // Wait-counter width; a disabled timeout still gets a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: clear, saturating increment, terminal count.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = cnt_width(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam bit              EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, increment only while enabled and below saturation.
  always_comb begin
    cnt_d = cnt;
    if (clr)
      cnt_d = '0;
    else if (inc && EN && (cnt != MAX))
      cnt_d = cnt + CNT_W'(1);
  end

  dff #(.W(CNT_W), .RST_VAL('0)) u_cnt (.clk(clk), .rst_n(rst_n), .d(cnt_d), .q(cnt));

  assign tc = EN && (cnt == LAST);

endmodule

// File: rtl/dff.sv
// Generic D flop with asynchronous active-low reset to a parameterised value.
module dff #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register d, forcing RST_VAL while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB initiator with ACCESS timeout and response channel.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  state_t              state, state_d;
  status_t             status, status_d;
  logic                pwrite_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                accept;
  logic                done_ok;
  logic                done_abort;
  logic                timer_tc;

  assign cmd_ready  = (state == IDLE) | ((state == RESP) & rsp_ready);
  assign accept     = cmd_valid & cmd_ready;
  // A ready slave in the terminal-count cycle still completes successfully.
  assign done_ok    = (state == ACCESS) & pready;
  assign done_abort = (state == ACCESS) & ~pready & timer_tc;

  // Transfer sequencing: IDLE -> SETUP -> ACCESS (waits) -> RESP -> SETUP/IDLE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done_ok || done_abort) state_d = RESP;
      RESP:    if (rsp_ready) state_d = cmd_valid ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture on accept; response capture on completion or abort.
  always_comb begin
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_rdata_d = rsp_rdata;
    status_d    = status;
    if (accept) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
    end
    if (done_ok) begin
      rsp_rdata_d = pwrite ? '0 : prdata;
      status_d    = OK;
    end else if (done_abort) begin
      rsp_rdata_d = '0;
      status_d    = TIMEOUT;
    end
  end

  dff #(.W(2),      .RST_VAL(IDLE)) u_state  (.clk(pclk), .rst_n(presetn), .d(state_d),     .q(state));
  dff #(.W(1),      .RST_VAL(OK))   u_status (.clk(pclk), .rst_n(presetn), .d(status_d),    .q(status));
  dff #(.W(1),      .RST_VAL('0))   u_pwrite (.clk(pclk), .rst_n(presetn), .d(pwrite_d),    .q(pwrite));
  dff #(.W(ADDR_W), .RST_VAL('0))   u_paddr  (.clk(pclk), .rst_n(presetn), .d(paddr_d),     .q(paddr));
  dff #(.W(DATA_W), .RST_VAL('0))   u_pwdata (.clk(pclk), .rst_n(presetn), .d(pwdata_d),    .q(pwdata));
  dff #(.W(DATA_W), .RST_VAL('0))   u_rdata  (.clk(pclk), .rst_n(presetn), .d(rsp_rdata_d), .q(rsp_rdata));

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk  (pclk),
    .rst_n(presetn),
    .clr  (state == SETUP),
    .inc  ((state == ACCESS) & ~pready),
    .tc   (timer_tc)
  );

  assign psel        = (state == SETUP) | (state == ACCESS);
  assign penable     = (state == ACCESS);
  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE);
  assign rsp_timeout = (status == TIMEOUT);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized checks of apb_master_bridge against a transfer-level model.
module tb_apb_master_bridge;

  localparam int unsigned T_A = 16;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0, pready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, prdata = '0;
  logic        use_b = 1'b0;

  logic        cr_a, rv_a, rto_a, bsy_a, ps_a, pe_a, pw_a;
  logic [31:0] rd_a, pa_a, pwd_a;
  logic        cr_b, rv_b, rto_b, bsy_b, ps_b, pe_b, pw_b;
  logic [31:0] rd_b, pa_b, pwd_b;

  logic        cr, rv, rto, bsy, ps, pe, pw;
  logic [31:0] rd, pa, pwd;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T_A)) dut_a (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmd_valid & ~use_b), .cmd_ready(cr_a),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_timeout(rto_a),
    .busy(bsy_a), .psel(ps_a), .penable(pe_a), .pwrite(pw_a), .paddr(pa_a),
    .pwdata(pwd_a), .pready(pready), .prdata(prdata));

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0)) dut_b (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmd_valid & use_b), .cmd_ready(cr_b),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_timeout(rto_b),
    .busy(bsy_b), .psel(ps_b), .penable(pe_b), .pwrite(pw_b), .paddr(pa_b),
    .pwdata(pwd_b), .pready(pready), .prdata(prdata));

  assign cr  = use_b ? cr_b  : cr_a;
  assign rv  = use_b ? rv_b  : rv_a;
  assign rto = use_b ? rto_b : rto_a;
  assign bsy = use_b ? bsy_b : bsy_a;
  assign ps  = use_b ? ps_b  : ps_a;
  assign pe  = use_b ? pe_b  : pe_a;
  assign pw  = use_b ? pw_b  : pw_a;
  assign rd  = use_b ? rd_b  : rd_a;
  assign pa  = use_b ? pa_b  : pa_a;
  assign pwd = use_b ? pwd_b : pwd_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transfer-level model: a slave that stays not-ready for 'waits' ACCESS cycles.
  function automatic bit exp_to(input int unsigned waits, input int unsigned t);
    return (t != 0) && (waits >= t);
  endfunction

  function automatic int unsigned exp_len(input int unsigned waits, input int unsigned t);
    return exp_to(waits, t) ? t : waits + 1;
  endfunction

  // One complete transfer from an idle bridge, response held for 'hold' cycles.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdv, input int unsigned waits, input int unsigned hold);
    int unsigned t = use_b ? 0 : T_A;
    int unsigned n = 0;
    logic [31:0] erd;
    @(negedge pclk);
    chk("idle_cmd_ready", cr, 1);
    chk("idle_psel", ps, 0);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = 0; prdata = rdv;
    @(negedge pclk);
    cmd_valid = 0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("setup_psel", ps, 1);
    chk("setup_penable", pe, 0);
    chk("setup_pwrite", pw, wr);
    chk("setup_paddr", pa, addr);
    chk("setup_pwdata", pwd, wdata);
    chk("setup_busy", bsy, 1);
    chk("setup_cmd_ready", cr, 0);
    @(negedge pclk);
    while (ps && pe && n < 300) begin
      chk("access_paddr", pa, addr);
      chk("access_pwdata", pwd, wdata);
      pready = (n >= waits);
      n++;
      @(negedge pclk);
    end
    pready = 0;
    erd = (wr || exp_to(waits, t)) ? 32'h0 : rdv;
    chk("access_len", n, exp_len(waits, t));
    chk("resp_psel", ps, 0);
    chk("resp_penable", pe, 0);
    chk("resp_valid", rv, 1);
    chk("resp_rdata", rd, erd);
    chk("resp_timeout", rto, exp_to(waits, t));
    chk("resp_busy", bsy, 1);
    chk("resp_cmd_ready", cr, 0);
    repeat (hold) begin
      @(negedge pclk);
      chk("hold_valid", rv, 1);
      chk("hold_rdata", rd, erd);
      chk("hold_timeout", rto, exp_to(waits, t));
    end
    rsp_ready = 1;
    #1 chk("resp_accept_ready", cr, 1);
    @(negedge pclk);
    rsp_ready = 0;
    chk("post_valid", rv, 0);
    chk("post_busy", bsy, 0);
  endtask

  initial begin
    // Reset state (combinational cmd_ready is high during reset)
    #12;
    chk("rst_cmd_ready", cr, 1);
    chk("rst_psel", ps, 0);
    chk("rst_penable", pe, 0);
    chk("rst_rsp_valid", rv, 0);
    chk("rst_rdata", rd, 0);
    chk("rst_timeout", rto, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_paddr", pa, 0);
    chk("rst_pwrite", pw, 0);
    chk("rst_pwdata", pwd, 0);
    @(negedge pclk);
    presetn = 1;

    // Zero-wait write, then read with 3 wait states
    xfer(1'b1, 32'h0C, 32'h1B, 32'hDEAD_BEEF, 0, 0);
    xfer(1'b0, 32'h04, 32'h0, 32'h0000_0005, 3, 1);

    // Timeout boundary: stuck slave aborts after 16; ready on the 16th succeeds
    xfer(1'b0, 32'h08, 32'h0, 32'h1234_5678, 40, 2);
    xfer(1'b0, 32'h08, 32'h0, 32'h1234_5678, 15, 0);
    xfer(1'b0, 32'h08, 32'h0, 32'h1234_5678, 16, 0);

    // Back-to-back writes at a 3-cycle cadence, then a stalled response
    @(negedge pclk);
    rsp_ready = 1; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hA1;
    @(negedge pclk);
    cmd_valid = 0;
    chk("b2b_setup1", {ps, pe, pa}, {2'b10, 32'h10});
    @(negedge pclk);
    chk("b2b_access1", {ps, pe}, 2'b11);
    pready = 1;
    @(negedge pclk);
    pready = 0;
    chk("b2b_resp1", {rv, ps}, 2'b10);
    cmd_valid = 1; cmd_addr = 32'h14; cmd_wdata = 32'hA2;
    #1 chk("b2b_cmd_ready", cr, 1);
    @(negedge pclk);
    cmd_valid = 0;
    chk("b2b_setup2", {ps, pe, pa, pwd}, {2'b10, 32'h14, 32'hA2});
    @(negedge pclk);
    chk("b2b_access2", {ps, pe}, 2'b11);
    pready = 1;
    @(negedge pclk);
    pready = 0;
    chk("b2b_resp2", {rv, rd}, {1'b1, 32'h0});
    rsp_ready = 0; cmd_valid = 1; cmd_addr = 32'h18; cmd_wdata = 32'hA3;
    repeat (5) begin
      @(negedge pclk);
      chk("stall_rsp", {rv, rto, rd}, {2'b10, 32'h0});
      chk("stall_cmd_ready", cr, 0);
      chk("stall_psel", ps, 0);
    end
    cmd_valid = 0; rsp_ready = 1;
    @(negedge pclk);
    rsp_ready = 0;
    chk("stall_idle", {rv, bsy}, 2'b00);
    chk("stall_not_accepted", pa, 32'h14);

    // Asynchronous reset in the middle of ACCESS
    @(negedge pclk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h08;
    @(negedge pclk);
    cmd_valid = 0;
    @(negedge pclk);
    chk("pre_rst_access", {ps, pe}, 2'b11);
    #2 presetn = 0;
    #1;
    chk("async_rst_psel", ps, 0);
    chk("async_rst_penable", pe, 0);
    chk("async_rst_valid", rv, 0);
    chk("async_rst_busy", bsy, 0);
    chk("async_rst_cmd_ready", cr, 1);
    @(negedge pclk);
    presetn = 1;
    xfer(1'b1, 32'h20, 32'h0A, 32'h5555_5555, 0, 0);

    // Randomized transfers on the 16-cycle-timeout bridge
    for (int i = 0; i < 24; i++) begin
      int unsigned r = $urandom_range(0, 9);
      int unsigned w = (r < 6) ? r % 4 : (r == 6) ? 15 : (r == 7) ? 16 : $urandom_range(17, 25);
      xfer(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
           w, $urandom_range(0, 3));
    end

    // Timeout disabled: a 100-cycle stall must still complete normally
    use_b = 1;
    xfer(1'b0, 32'h30, 32'h0, 32'h0000_CAFE, 100, 0);
    for (int i = 0; i < 4; i++)
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           $urandom_range(0, 40), $urandom_range(0, 2));
    use_b = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB initiator that turns a simple valid/ready command stream into compliant APB SETUP/ACCESS transfers. It drives the UART register slave from a local controller, such as a DMA or host sequencer. It waits on pready, aborts a stalled transfer after a programmable timeout, and returns read data and status on a valid/ready response channel. One transfer is outstanding at a time.

Parameters:
ADDR_W, 32, width of cmd_addr and paddr
DATA_W, 32, width of write data and read data
TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles before abort; 0 disables the timeout
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the wait counter (derived)

Ports:
pclk  in  1  clock
presetn  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts
rsp_timeout  out  1  transfer aborted by timeout
busy  out  1  state != IDLE
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pready  in  1  APB slave ready
prdata  in  DATA_W  APB read data

Behaviour:
- Single clock pclk. Reset presetn is asynchronous, active-low.
- Reset values: state=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; rsp_valid=0, rsp_rdata=0, rsp_timeout=0, busy=0; wait counter=0.
- cmd_ready = (state==IDLE) | (state==RESP & rsp_ready). It is combinational and is 1 during reset. cmd_* inputs are ignored when cmd_ready=0.
- State machine, one-hot or encoded:
  - IDLE: on cmd_valid&cmd_ready, register cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
  - SETUP: psel=1, penable=0. Lasts exactly 1 cycle, then go to ACCESS. The wait counter is cleared on entry.
  - ACCESS: psel=1, penable=1.
    - pready=1 sampled: capture prdata into rsp_rdata if pwrite=0, else load rsp_rdata=0. Set rsp_timeout=0 and go to RESP.
    - pready=0 and TIMEOUT_CYCLES!=0 and cnt==TIMEOUT_CYCLES-1: abort. Set rsp_rdata=0, rsp_timeout=1, go to RESP.
    - Otherwise cnt++ and stay in ACCESS.
    - pready=1 in the abort cycle counts as success; success wins over timeout.
  - RESP: psel=0, penable=0, rsp_valid=1. rsp_rdata and rsp_timeout stay stable until rsp_ready.
    - On rsp_ready with cmd_valid: accept the new command directly into SETUP.
    - On rsp_ready without cmd_valid: go to IDLE.
- Latency: command accepted at edge k gives SETUP in cycle k+1 and first ACCESS in cycle k+2. With pready=1 there, rsp_valid=1 from cycle k+3.
- Throughput: sustained transfers run at 3 cycles each with zero wait states and rsp_ready held 1.
- paddr, pwrite and pwdata are stable from SETUP through the final ACCESS cycle. They hold their last value while idle.
- psel never deasserts mid-transfer except on timeout abort or reset.
- Maximum ACCESS length is TIMEOUT_CYCLES cycles. The counter saturates and never wraps.
- Reset mid-operation: all outputs return to reset values asynchronously and any pending response is discarded. The slave sees psel drop without completion, which is accepted by design.
- busy=1 in SETUP, ACCESS and RESP.

Decomposition:
- Package apb_master_pkg:
  - state typedef: IDLE, SETUP, ACCESS, RESP.
  - localparam defaults for ADDR_W, DATA_W, TIMEOUT_CYCLES.
  - response-status typedef: OK, TIMEOUT.
- Registers use the existing dff flop cell with reset values as listed above.
- Sub-module apb_wait_timer: a clear/increment counter with a terminal-count output, parameterised by TIMEOUT_CYCLES and gated off when the parameter is 0.

Test Plan:
1. Write, addr 0x0C, wdata 0x1B, pready=1 throughout:
   - SETUP for 1 cycle with psel=1, penable=0, pwrite=1, paddr=0x0C, pwdata=0x1B.
   - ACCESS for 1 cycle.
   - rsp_valid 3 cycles after accept, with rsp_rdata=0 and rsp_timeout=0.
2. Read, addr 0x04; pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0x00000005:
   - penable high for 4 cycles with paddr stable.
   - rsp_rdata=0x00000005, rsp_timeout=0.
3. Read with pready stuck 0, TIMEOUT_CYCLES=16:
   - exactly 16 ACCESS cycles, then psel and penable drop.
   - rsp_timeout=1, rsp_rdata=0.
   - pready=1 on the 16th cycle instead gives success with no timeout.
4. Two writes back-to-back with rsp_ready=1:
   - second SETUP immediately follows the first RESP, for a 3-cycle cadence.
   - Then rsp_ready=0 for 5 cycles: rsp stays stable, cmd_ready=0, psel=0, new command is not accepted.
5. presetn asserted low during ACCESS of a read:
   - psel, penable, rsp_valid and busy go to 0 immediately, without waiting for a clock edge.
   - After release, cmd_ready=1 and a write to 0x20 with 0x0A completes normally.
6. TIMEOUT_CYCLES=0 with pready held 0 for 100 cycles:
   - transfer still pending, no abort.
   - pready=1 completes it normally.
